// File: rtl/regfile_streamer_if.sv
// Regfile bus plus dump/load valid/ready streams for regfile_streamer.
// master = the streamer, slave = regfile / stream endpoints.
interface regfile_streamer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we_;
    logic [DATA_W-1:0] rf_rdata;
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] l_data;
    logic              l_valid;
    logic              l_ready;

    modport master (
        output rf_addr, rf_wdata, rf_we_, s_data, s_valid, l_ready,
        input  rf_rdata, s_ready, l_data, l_valid
    );

    modport slave (
        input  rf_addr, rf_wdata, rf_we_, s_data, s_valid, l_ready,
        output rf_rdata, s_ready, l_data, l_valid
    );
endinterface

// File: rtl/regfile_streamer.sv
// Sequencing master for the single-port regfile: DUMP streams words 0..DATA_D-1 out,
// LOAD writes DATA_D streamed words in. Optional checksum output under `RF_CSUM_EN.
module regfile_streamer #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_D = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start_dump_,
    input  logic              start_load_,
    output logic              busy,
    output logic              done,
`ifdef RF_CSUM_EN
    output logic [DATA_W-1:0] csum,
`endif
    regfile_streamer_if.master bus
);
    typedef enum logic [1:0] {IDLE, DUMP, LOAD, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DATA_D - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic              beat;
    logic              start;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (start)
                idx <= '0;
            else if (beat && idx != LAST_IDX)
                idx <= idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        done         = 1'b0;
        beat         = 1'b0;
        start        = 1'b0;
        bus.rf_addr  = '0;
        bus.rf_wdata = bus.l_data;
        bus.rf_we_   = 1'b1;
        bus.s_data   = bus.rf_rdata;
        bus.s_valid  = 1'b0;
        bus.l_ready  = 1'b0;
        case (state)
            IDLE: begin
                // Dump has priority when both requests arrive together.
                if (!start_dump_) begin
                    state_nxt = DUMP;
                    start     = 1'b1;
                end else if (!start_load_) begin
                    state_nxt = LOAD;
                    start     = 1'b1;
                end
            end
            DUMP: begin
                busy        = 1'b1;
                bus.rf_addr = idx;
                bus.s_valid = 1'b1;
                beat        = bus.s_ready;
                if (beat && idx == LAST_IDX)
                    state_nxt = DONE;
            end
            LOAD: begin
                busy        = 1'b1;
                bus.rf_addr = idx;
                bus.l_ready = 1'b1;
                bus.rf_we_  = ~bus.l_valid;
                beat        = bus.l_valid;
                if (beat && idx == LAST_IDX)
                    state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef RF_CSUM_EN
    logic [DATA_W-1:0] word;

    assign word = (state == LOAD) ? bus.l_data : bus.s_data;

    always_ff @(posedge clk) begin
        if (!reset_)
            csum <= '0;
        else if (start)
            csum <= '0;
        else if (beat)
            csum <= csum + word;
    end
`endif
endmodule
